// File: rtl/tetris_board_renderer.sv
// Playfield pixel generator: board-RAM lookup, fixed palette, grid lines
// and a frame-counted row-clear flash, two-stage pipeline from pix_en.
module tetris_board_renderer #(
    parameter int COLS         = 12,
    parameter int ROWS         = 22,
    parameter int CELL         = 20,
    parameter int ORG_X        = 200,
    parameter int ORG_Y        = 20,
    parameter int CODE_W       = 3,
    parameter int GRID         = 1,
    parameter int FLASH_FRAMES = 30,
    parameter int FLASH_PERIOD = 6,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [RW-1:0]     cell_row,
    output logic [CW-1:0]     cell_col,
    input  logic [CODE_W-1:0] cell_code,
    input  logic [ROWS-1:0]   clear_mask,
    input  logic              flash_start,
    output logic              flash_busy,
    output logic              flash_done,
    output logic              pix_valid,
    output logic [3:0]        Red,
    output logic [3:0]        Green,
    output logic [3:0]        Blue
);

    localparam int XW = $clog2(CELL);
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int PW = $clog2(FLASH_PERIOD + 1);

    localparam logic [9:0] X0 = 10'(ORG_X);
    localparam logic [9:0] X1 = 10'(ORG_X + COLS * CELL);
    localparam logic [9:0] Y0 = 10'(ORG_Y);
    localparam logic [9:0] Y1 = 10'(ORG_Y + ROWS * CELL);
    localparam logic [XW-1:0] XLAST = XW'(CELL - 1);

    typedef enum logic {S_IDLE, S_FLASH} state_e;

    logic [XW-1:0] xs_q, ys_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    logic          at_x0, at_y0;
    logic [XW-1:0] xs_c, xs_d, ys_s, ys_c;
    logic [CW-1:0] col_c, col_d;
    logic [RW-1:0] row_s, row_c;
    logic          in_board_c, edge_c, row_ok, hit_c;

    state_e          state_q;
    logic [ROWS-1:0] mask_q;
    logic [FW-1:0]   fcnt_q;
    logic [PW-1:0]   pcnt_q;
    logic            odd_q;
    logic            frame_b;

    logic        v1_q, inb_q, edge_q, hit_q;
    logic [11:0] rgb_c;

    assign at_x0 = (DrawX == X0);
    assign at_y0 = (DrawY == Y0);

    // xs_q/col_q hold the values for the next pixel on the line
    assign xs_c  = at_x0 ? '0 : xs_q;
    assign col_c = at_x0 ? '0 : col_q;
    assign xs_d  = (xs_c == XLAST) ? '0 : xs_c + 1'b1;
    assign col_d = (xs_c == XLAST) ? col_c + 1'b1 : col_c;

    // ys_q/row_q hold the current line's values, refreshed at the board's left edge
    assign ys_s  = at_y0 ? '0 : ((ys_q == XLAST) ? '0 : ys_q + 1'b1);
    assign row_s = at_y0 ? '0 : ((ys_q == XLAST) ? row_q + 1'b1 : row_q);
    assign ys_c  = at_x0 ? ys_s : ys_q;
    assign row_c = at_x0 ? row_s : row_q;

    assign in_board_c = (DrawX >= X0) && (DrawX < X1) &&
                        (DrawY >= Y0) && (DrawY < Y1);
    assign edge_c = (xs_c == '0) || (ys_c == '0);
    assign row_ok = ({1'b0, row_c} < (RW + 1)'(ROWS));
    assign hit_c  = flash_busy && !odd_q && row_ok && mask_q[row_c];

    assign frame_b = pix_en && (DrawX == '0) && (DrawY == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            xs_q  <= '0;
            col_q <= '0;
            ys_q  <= '0;
            row_q <= '0;
        end else if (pix_en) begin
            xs_q  <= xs_d;
            col_q <= col_d;
            if (at_x0) begin
                ys_q  <= ys_s;
                row_q <= row_s;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            fcnt_q     <= '0;
            pcnt_q     <= '0;
            odd_q      <= 1'b0;
            flash_busy <= 1'b0;
            flash_done <= 1'b0;
        end else begin
            flash_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // a start coinciding with the done pulse is dropped
                    if (flash_start && !flash_done) begin
                        state_q    <= S_FLASH;
                        mask_q     <= clear_mask;
                        fcnt_q     <= '0;
                        pcnt_q     <= '0;
                        odd_q      <= 1'b0;
                        flash_busy <= 1'b1;
                    end
                end
                S_FLASH: begin
                    if (frame_b) begin
                        fcnt_q <= fcnt_q + 1'b1;
                        if (pcnt_q == PW'(FLASH_PERIOD - 1)) begin
                            pcnt_q <= '0;
                            odd_q  <= ~odd_q;
                        end else begin
                            pcnt_q <= pcnt_q + 1'b1;
                        end
                        if (fcnt_q == FW'(FLASH_FRAMES - 1)) begin
                            state_q    <= S_IDLE;
                            flash_busy <= 1'b0;
                            flash_done <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1_q     <= 1'b0;
            cell_row <= '0;
            cell_col <= '0;
            inb_q    <= 1'b0;
            edge_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            v1_q <= pix_en;
            if (pix_en) begin
                cell_row <= row_c;
                cell_col <= col_c;
                inb_q    <= in_board_c;
                edge_q   <= edge_c;
                hit_q    <= hit_c;
            end
        end
    end

    always_comb begin
        rgb_c = 12'h000;
        if (!inb_q) begin
            rgb_c = 12'h000;
        end else if (hit_q) begin
            rgb_c = 12'hFFF;
        end else if (cell_code > CODE_W'(7)) begin
            rgb_c = 12'h888;
        end else begin
            unique case (cell_code[2:0])
                3'd0: rgb_c = ((GRID != 0) && edge_q) ? 12'hCCC : 12'hFFF;
                3'd1: rgb_c = 12'h0FF;
                3'd2: rgb_c = 12'h00F;
                3'd3: rgb_c = 12'hF80;
                3'd4: rgb_c = 12'hFF0;
                3'd5: rgb_c = 12'h0F0;
                3'd6: rgb_c = 12'h80F;
                3'd7: rgb_c = 12'hF00;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_valid <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
        end else begin
            pix_valid <= v1_q;
            if (v1_q) begin
                {Red, Green, Blue} <= rgb_c;
            end
        end
    end

endmodule
